sp_commit_trace: RTL and testbench
==================================

SP_COMMIT_TRACE -- requirements
Module: sp_commit_trace

Interface
REQ-001 SHALL have parameter DEPTH, default 4, trace FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter ADDR_WIDTH, default sp_pkg::ADDR_WIDTH, PC and dmem address width.
REQ-003 SHALL have port clk_i  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port arst_ni  input  1  asynchronous active-low reset.
REQ-005 SHALL have port clear_i  input  1  synchronous flush of FIFO and sequence counter.
REQ-006 SHALL have port retire_valid_i  input  1  core retires one instruction this cycle.
REQ-007 SHALL have port retire_ready_o  output  1  tracer accepts a retire (core stalls when low).
REQ-008 SHALL have port retire_i  input  trace_entry_t minus seq  fields: pc[ADDR_WIDTH], instr[32], gpr_we, gpr_addr[5], gpr_data[32], dmem_op, dmem_we, dmem_addr[ADDR_WIDTH], dmem_data[32].
REQ-009 SHALL have port trace_valid_o  output  1  head entry available to checker.
REQ-010 SHALL have port trace_ready_i  input  1  checker consumes head entry.
REQ-011 SHALL have port trace_o  output  trace_entry_t  head entry, including seq[32].
REQ-012 SHALL have port count_o  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-013 SHALL capture a retire when retire_valid_i && retire_ready_o at the clock edge (push).
REQ-014 SHALL drive retire_ready_o = !full, purely combinational on occupancy; no dependency on trace_ready_i.
REQ-015 SHALL stamp each pushed entry with seq = number of prior pushes since reset/clear, starting at 0, wrapping 2^32-1 -> 0.
REQ-016 SHALL drive trace_valid_o = !empty; trace_o = oldest entry; push-to-valid latency one cycle (no bypass).
REQ-017 SHALL pop on trace_valid_o && trace_ready_i at the clock edge.
REQ-018 SHALL, on simultaneous push and pop, keep occupancy unchanged; when full, push is blocked even if pop occurs same cycle.
REQ-019 SHALL hold trace_o and trace_valid_o stable while trace_valid_o && !trace_ready_i.
REQ-020 SHALL wrap read and write pointers modulo DEPTH; full = count==DEPTH, empty = count==0.
REQ-021 SHALL, on clear_i, empty FIFO and zero seq next edge, ignoring any same-cycle push/pop; clear has priority.
REQ-022 SHALL leave entry contents unmasked when gpr_we=0 or dmem_op=0 (fields passed verbatim; checker qualifies).
REQ-023 SHALL never drop or reorder a pushed entry.

Reset
REQ-024 SHALL, on arst_ni low, asynchronously set count_o=0, trace_valid_o=0, retire_ready_o=1, pointers=0, seq=0.
REQ-025 SHALL leave storage array unreset; trace_o is don't-care while trace_valid_o=0.
REQ-026 SHALL discard in-flight entries on reset mid-operation; first post-reset push carries seq=0.

Structure
REQ-027 SHALL take trace_entry_t (packed struct, fields per REQ-008 plus seq) from sp_pkg, alongside ADDR_WIDTH.
REQ-028 SHALL instantiate one sub-module, sp_fifo (parameterised width/depth, valid/ready both sides, clear_i); sequence counter and field packing live in sp_commit_trace.
REQ-029 SHALL field order in trace_entry_t match the model-query order: pc, instr, gpr_we, gpr_addr, gpr_data, dmem_op, dmem_we, dmem_addr, dmem_data, seq.

Verification
REQ-030 SHALL cover single retire: pc=0x100, instr=0x00A00093, gpr_we=1, gpr_addr=1, gpr_data=10, trace_ready_i=1 -> trace_valid_o high next cycle, trace_o matches, seq=0, count_o returns 0.
REQ-031 SHALL cover fill: DEPTH=4, trace_ready_i=0, 6 retires offered -> 4 accepted, retire_ready_o low after 4th, count_o=4; then ready=1 -> seq 0,1,2,3 in order, then remaining 2 accepted as seq 4,5.
REQ-032 SHALL cover simultaneous push/pop at count=2 -> count stays 2, popped seq=n, pushed entry appears after existing two.
REQ-033 SHALL cover store entry: dmem_op=1, dmem_we=1, dmem_addr=0x2000, dmem_data=0xDEADBEEF -> fields exact, matches model_is_dmem_we/model_dmem_addr/model_dmem_data after model_step.
REQ-034 SHALL cover clear_i and arst_ni asserted with count=3 and a same-cycle push -> count_o=0, trace_valid_o=0, next push seq=0.
REQ-035 SHALL cover lockstep random run of 10000 retires with random trace_ready_i, each entry compared to model_step result; zero mismatches, no seq gaps.

Source files
------------

// File: rtl/sp_pkg.sv
// rtl/sp_pkg.sv - shared types for the commit tracer
package sp_pkg;

  localparam int ADDR_WIDTH = 32;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [31:0]           instr;
    logic                  gpr_we;
    logic [4:0]            gpr_addr;
    logic [31:0]           gpr_data;
    logic                  dmem_op;
    logic                  dmem_we;
    logic [ADDR_WIDTH-1:0] dmem_addr;
    logic [31:0]           dmem_data;
  } retire_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [31:0]           instr;
    logic                  gpr_we;
    logic [4:0]            gpr_addr;
    logic [31:0]           gpr_data;
    logic                  dmem_op;
    logic                  dmem_we;
    logic [ADDR_WIDTH-1:0] dmem_addr;
    logic [31:0]           dmem_data;
    logic [31:0]           seq;
  } trace_entry_t;

endpackage

// File: rtl/sp_fifo.sv
// rtl/sp_fifo.sv - synchronous valid/ready FIFO with flush
module sp_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       arst_ni,
  input  logic                       clear_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [WIDTH-1:0]           in_data_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [WIDTH-1:0]           out_data_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             pop;

  // Ready depends only on occupancy, so a full FIFO refuses even when popping.
  assign in_ready_o  = (count != CNT_W'(DEPTH));
  assign out_valid_o = (count != '0);
  assign out_data_o  = mem[rptr];
  assign count_o     = count;
  assign push        = in_valid_i && in_ready_o;
  assign pop         = out_valid_o && out_ready_i;

  always_ff @(posedge clk_i) begin
    if (push && !clear_i) begin
      mem[wptr] <= in_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (clear_i) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sp_commit_trace.sv
// rtl/sp_commit_trace.sv - stamps retired instructions with a sequence number and queues them for the checker
module sp_commit_trace
  import sp_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = sp_pkg::ADDR_WIDTH
) (
  input  logic                     clk_i,
  input  logic                     arst_ni,
  input  logic                     clear_i,
  input  logic                     retire_valid_i,
  output logic                     retire_ready_o,
  input  retire_t                  retire_i,
  output logic                     trace_valid_o,
  input  logic                     trace_ready_i,
  output trace_entry_t             trace_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int ENTRY_W = $bits(trace_entry_t);

  trace_entry_t entry;
  logic [31:0]  seq_q;
  logic         push;

  assign push = retire_valid_i && retire_ready_o;

  // Fields are passed verbatim; the checker qualifies them by gpr_we/dmem_op.
  always_comb begin
    entry           = '0;
    entry.pc        = retire_i.pc[ADDR_WIDTH-1:0];
    entry.instr     = retire_i.instr;
    entry.gpr_we    = retire_i.gpr_we;
    entry.gpr_addr  = retire_i.gpr_addr;
    entry.gpr_data  = retire_i.gpr_data;
    entry.dmem_op   = retire_i.dmem_op;
    entry.dmem_we   = retire_i.dmem_we;
    entry.dmem_addr = retire_i.dmem_addr[ADDR_WIDTH-1:0];
    entry.dmem_data = retire_i.dmem_data;
    entry.seq       = seq_q;
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      seq_q <= '0;
    end else if (clear_i) begin
      seq_q <= '0;
    end else if (push) begin
      seq_q <= seq_q + 32'd1;
    end
  end

  sp_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .arst_ni     (arst_ni),
    .clear_i     (clear_i),
    .in_valid_i  (retire_valid_i),
    .in_ready_o  (retire_ready_o),
    .in_data_i   (entry),
    .out_valid_o (trace_valid_o),
    .out_ready_i (trace_ready_i),
    .out_data_o  (trace_o),
    .count_o     (count_o)
  );

endmodule

// File: tb/tb_sp_commit_trace.sv
// tb/tb_sp_commit_trace.sv - directed and random checks of sp_commit_trace against a queue model
module tb_sp_commit_trace;
  import sp_pkg::*;

  localparam int DEPTH = 4;

  logic                 clk = 1'b0;
  logic                 arst_n = 1'b0;
  logic                 clear = 1'b0;
  logic                 retire_valid = 1'b0;
  logic                 retire_ready;
  retire_t              retire = '0;
  logic                 trace_valid;
  logic                 trace_ready = 1'b0;
  trace_entry_t         trace;
  logic [$clog2(DEPTH):0] count;

  int checks = 0;
  int errors = 0;

  trace_entry_t mq[$];
  logic [31:0]  pop_log[$];
  logic [31:0]  mseq = '0;

  always #5 clk = ~clk;

  sp_commit_trace #(.DEPTH(DEPTH)) dut (
    .clk_i          (clk),
    .arst_ni        (arst_n),
    .clear_i        (clear),
    .retire_valid_i (retire_valid),
    .retire_ready_o (retire_ready),
    .retire_i       (retire),
    .trace_valid_o  (trace_valid),
    .trace_ready_i  (trace_ready),
    .trace_o        (trace),
    .count_o        (count)
  );

  function automatic trace_entry_t model_step(input retire_t r, input logic [31:0] s);
    trace_entry_t e;
    e.pc = r.pc; e.instr = r.instr; e.gpr_we = r.gpr_we; e.gpr_addr = r.gpr_addr;
    e.gpr_data = r.gpr_data; e.dmem_op = r.dmem_op; e.dmem_we = r.dmem_we;
    e.dmem_addr = r.dmem_addr; e.dmem_data = r.dmem_data; e.seq = s;
    return e;
  endfunction

  function automatic logic model_is_dmem_we(input trace_entry_t e);
    return e.dmem_op && e.dmem_we;
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] model_dmem_addr(input trace_entry_t e);
    return e.dmem_addr;
  endfunction

  function automatic logic [31:0] model_dmem_data(input trace_entry_t e);
    return e.dmem_data;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Model: FIFO of stamped entries, updated from the inputs seen at each edge.
  always @(posedge clk) begin
    if (arst_n) begin
      if (clear) begin
        mq.delete();
        mseq = '0;
      end else begin
        automatic logic do_pop  = (mq.size() != 0) && trace_ready;
        automatic logic do_push = retire_valid && (mq.size() < DEPTH);
        if (do_pop) begin
          pop_log.push_back(mq[0].seq);
          void'(mq.pop_front());
        end
        if (do_push) begin
          mq.push_back(model_step(retire, mseq));
          mseq = mseq + 32'd1;
        end
      end
    end
  end

  always @(negedge arst_n) begin
    mq.delete();
    mseq = '0;
  end

  always @(negedge clk) begin
    chk("cmp_valid", 256'(trace_valid), 256'(mq.size() != 0));
    chk("cmp_count", 256'(count), 256'(mq.size()));
    chk("cmp_ready", 256'(retire_ready), 256'(mq.size() < DEPTH));
    if (mq.size() != 0) chk("cmp_head", 256'(trace), 256'(mq[0]));
  end

  function automatic retire_t mk(input logic [31:0] pc, input logic [31:0] instr);
    retire_t r;
    r = '0;
    r.pc = pc;
    r.instr = instr;
    return r;
  endfunction

  function automatic retire_t rnd();
    retire_t r;
    r.pc = $urandom; r.instr = $urandom; r.gpr_we = 1'($urandom_range(0, 1));
    r.gpr_addr = 5'($urandom); r.gpr_data = $urandom; r.dmem_op = 1'($urandom_range(0, 1));
    r.dmem_we = 1'($urandom_range(0, 1)); r.dmem_addr = $urandom; r.dmem_data = $urandom;
    return r;
  endfunction

  task automatic retire_one(input retire_t r);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk); #2;
      retire_valid = 1'b1;
      retire = r;
      ok = retire_ready;
      @(posedge clk);
    end
    @(negedge clk); #2;
    retire_valid = 1'b0;
    if (!ok) chk("retire_timeout", 256'(0), 256'(1));
  endtask

  task automatic do_clear();
    @(negedge clk); #2;
    clear = 1'b1; retire_valid = 1'b0; trace_ready = 1'b0;
    @(negedge clk); #2;
    clear = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    retire_t r;
    trace_entry_t e;
    int n, cyc;
    logic ok;

    idle(3);
    chk("reset_count", 256'(count), 256'(0));
    chk("reset_valid", 256'(trace_valid), 256'(0));
    chk("reset_ready", 256'(retire_ready), 256'(1));
    arst_n = 1'b1;
    idle(1);

    // Single retire, push-to-valid latency of one cycle
    r = mk(32'h100, 32'h00A00093);
    r.gpr_we = 1'b1; r.gpr_addr = 5'd1; r.gpr_data = 32'd10;
    trace_ready = 1'b1;
    chk("single_pre_valid", 256'(trace_valid), 256'(0));
    retire_one(r);
    chk("single_valid", 256'(trace_valid), 256'(1));
    chk("single_pc", 256'(trace.pc), 256'(32'h100));
    chk("single_instr", 256'(trace.instr), 256'(32'h00A00093));
    chk("single_gpr", 256'({trace.gpr_we, trace.gpr_addr, trace.gpr_data}), 256'({1'b1, 5'd1, 32'd10}));
    chk("single_seq", 256'(trace.seq), 256'(0));
    idle(1);
    chk("single_drain", 256'(count), 256'(0));

    // Fill: 6 offered while checker stalls
    do_clear();
    pop_log.delete();
    for (int i = 0; i < 4; i++) retire_one(mk(32'h1000 + 32'(i * 4), 32'h13));
    chk("fill_count", 256'(count), 256'(4));
    chk("fill_ready", 256'(retire_ready), 256'(0));
    idle(2);
    chk("fill_hold_seq", 256'(trace.seq), 256'(0));
    chk("fill_hold_pc", 256'(trace.pc), 256'(32'h1000));
    trace_ready = 1'b1;
    retire_one(mk(32'h1010, 32'h13));
    retire_one(mk(32'h1014, 32'h13));
    idle(6);
    chk("fill_pops", 256'(pop_log.size()), 256'(6));
    for (int i = 0; i < 6; i++)
      if (i < pop_log.size()) chk("fill_order", 256'(pop_log[i]), 256'(i));

    // Simultaneous push and pop at count=2
    do_clear();
    pop_log.delete();
    retire_one(mk(32'h2000, 32'h1));
    retire_one(mk(32'h2004, 32'h2));
    chk("pp_pre_count", 256'(count), 256'(2));
    retire_valid = 1'b1; retire = mk(32'h2008, 32'h3); trace_ready = 1'b1;
    @(posedge clk);
    @(negedge clk); #2;
    retire_valid = 1'b0; trace_ready = 1'b0;
    chk("pp_count", 256'(count), 256'(2));
    chk("pp_popped", 256'(pop_log.size() == 1 ? pop_log[0] : 32'hFFFF_FFFF), 256'(0));
    chk("pp_head_seq", 256'(trace.seq), 256'(1));
    trace_ready = 1'b1;
    idle(3);
    chk("pp_order", 256'(pop_log.size() == 3 ? {pop_log[1], pop_log[2]} : 64'h0), 256'({32'd1, 32'd2}));

    // Store entry
    do_clear();
    r = mk(32'h300, 32'h00112023);
    r.dmem_op = 1'b1; r.dmem_we = 1'b1; r.dmem_addr = 32'h2000; r.dmem_data = 32'hDEADBEEF;
    retire_one(r);
    e = model_step(r, 32'd0);
    chk("store_entry", 256'(trace), 256'(e));
    chk("store_we", 256'(trace.dmem_op && trace.dmem_we), 256'(model_is_dmem_we(e)));
    chk("store_addr", 256'(trace.dmem_addr), 256'(32'h2000));
    chk("store_data", 256'(trace.dmem_data), 256'(32'hDEADBEEF));
    chk("store_model", 256'({model_dmem_addr(e), model_dmem_data(e)}), 256'({32'h2000, 32'hDEADBEEF}));

    // Clear with count=3 and a same-cycle push
    do_clear();
    for (int i = 0; i < 3; i++) retire_one(mk(32'h400 + 32'(i), 32'h5));
    chk("clr_pre_count", 256'(count), 256'(3));
    clear = 1'b1; retire_valid = 1'b1; retire = mk(32'h4FF, 32'h5);
    @(posedge clk);
    @(negedge clk); #2;
    clear = 1'b0; retire_valid = 1'b0;
    chk("clr_count", 256'(count), 256'(0));
    chk("clr_valid", 256'(trace_valid), 256'(0));
    retire_one(mk(32'h500, 32'h6));
    chk("clr_next_seq", 256'(trace.seq), 256'(0));

    // Asynchronous reset with count=3 and a push in flight
    do_clear();
    for (int i = 0; i < 3; i++) retire_one(mk(32'h600 + 32'(i), 32'h7));
    retire_valid = 1'b1; retire = mk(32'h6FF, 32'h7);
    arst_n = 1'b0;
    #1;
    chk("rst_count", 256'(count), 256'(0));
    chk("rst_valid", 256'(trace_valid), 256'(0));
    chk("rst_ready", 256'(retire_ready), 256'(1));
    @(negedge clk); #2;
    retire_valid = 1'b0;
    arst_n = 1'b1;
    retire_one(mk(32'h700, 32'h8));
    chk("rst_next_seq", 256'(trace.seq), 256'(0));
    chk("rst_next_pc", 256'(trace.pc), 256'(32'h700));

    // Lockstep random run
    do_clear();
    pop_log.delete();
    n = 0; cyc = 0;
    r = rnd();
    while (n < 10000 && cyc < 60000) begin
      @(negedge clk); #2;
      retire_valid = 1'b1;
      retire = r;
      trace_ready = 1'($urandom_range(0, 1));
      ok = retire_ready;
      @(posedge clk);
      if (ok) begin
        n++;
        r = rnd();
      end
      cyc++;
    end
    @(negedge clk); #2;
    retire_valid = 1'b0;
    trace_ready = 1'b1;
    chk("rand_accepted", 256'(n), 256'(10000));
    for (int i = 0; i < 20 && count != 0; i++) idle(1);
    chk("rand_drained", 256'(count), 256'(0));
    chk("rand_pops", 256'(pop_log.size()), 256'(10000));
    if (pop_log.size() == 10000) chk("rand_last_seq", 256'(pop_log[9999]), 256'(9999));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
